// File: rtl/magia_pkg.sv
// AXI4 channel structs and response codes shared across the tile.
package magia_pkg;

  localparam int unsigned AXI_ID_W = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         data;
    logic [1:0]          resp;
    logic                last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_default_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_default_rsp_t;

endpackage

// File: rtl/magia_stdio_pkg.sv
// Register map, FSM states and address decode for the stdio window.
// Optional feature macro: MAGIA_STDIO_EOC_EN (enables the EOC register).
package magia_stdio_pkg;

  localparam logic [3:0]  STDIO_ERR_OFF = 4'h0;
  localparam logic [3:0]  STDIO_OUT_OFF = 4'h4;
  localparam logic [3:0]  STDIO_EOC_OFF = 4'h8;
  localparam logic [31:0] STDIO_ERR_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} stdio_state_e;

  // Write target resolved once at AW time; TGT_BAD means SLVERR, no side effects.
  typedef enum logic [1:0] {TGT_ERR, TGT_OUT, TGT_EOC, TGT_BAD} stdio_tgt_e;

  function automatic stdio_tgt_e stdio_decode(input logic [31:2] addr,
                                              input logic [31:4] base,
                                              input logic [7:0]  len);
    stdio_tgt_e tgt;
    tgt = TGT_BAD;
    if (addr[31:4] == base && len == 8'd0) begin
      if (addr[3:2] == STDIO_ERR_OFF[3:2])      tgt = TGT_ERR;
      else if (addr[3:2] == STDIO_OUT_OFF[3:2]) tgt = TGT_OUT;
`ifdef MAGIA_STDIO_EOC_EN
      else if (addr[3:2] == STDIO_EOC_OFF[3:2]) tgt = TGT_EOC;
`else
      else if (addr[3:2] == STDIO_EOC_OFF[3:2]) tgt = TGT_BAD;
`endif
    end
    return tgt;
  endfunction

endpackage

// File: rtl/magia_stdio_fifo.sv
// Synchronous 8-bit character FIFO; push and pop may coincide, even when full.
module magia_stdio_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Character storage.
  // NOTE: storage is deliberately not reset; empty pointers mask stale data and an unreset array maps to plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/magia_axi_stdio.sv
// AXI4 write sink for the stdio/status window: stderr, stdout FIFO, EOC.
// Optional feature macro: MAGIA_STDIO_EOC_EN (EOC register and its ports).
module magia_axi_stdio
  import magia_stdio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter type         axi_req_t  = magia_pkg::axi_default_req_t,
  parameter type         axi_rsp_t  = magia_pkg::axi_default_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  axi_req_t    axi_req_i,
  output axi_rsp_t    axi_rsp_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        err_valid_o,
  output logic [31:0] err_code_o
`ifdef MAGIA_STDIO_EOC_EN
  ,
  output logic        eoc_valid_o,
  output logic [31:0] exit_code_o
`endif
);

  stdio_state_e                    state_q, state_d;
  stdio_tgt_e                      tgt_q;
  logic [magia_pkg::AXI_ID_W-1:0]  id_q;
  logic [7:0]                      cnt_q;
  logic aw_ready, ar_ready, w_ready, b_valid, r_valid, push_req;
  logic aw_hs, ar_hs, w_hs, r_hs;
  logic fifo_full, fifo_empty;
  logic unused_req;

  // Request fields this sink never needs.
  assign unused_req = ^{axi_req_i.aw.addr[1:0], axi_req_i.aw.size, axi_req_i.aw.burst,
                        axi_req_i.ar.addr, axi_req_i.ar.size, axi_req_i.ar.burst};

  assign aw_hs = axi_req_i.aw_valid && aw_ready;
  assign ar_hs = axi_req_i.ar_valid && ar_ready;
  assign w_hs  = axi_req_i.w_valid  && w_ready;
  assign r_hs  = axi_req_i.r_ready  && r_valid;

  // Next-state and handshake outputs; everything forced low while in reset.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    aw_ready = 1'b0;
    ar_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    r_valid  = 1'b0;
    push_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        aw_ready = 1'b1;
        ar_ready = !axi_req_i.aw_valid;
        if (axi_req_i.aw_valid)      state_d = WDATA;
        else if (axi_req_i.ar_valid) state_d = RDATA;
      end
      WDATA: begin
        push_req = (tgt_q == TGT_OUT) && axi_req_i.w.strb[0];
        w_ready  = !(push_req && fifo_full);
        if (axi_req_i.w_valid && w_ready && axi_req_i.w.last) state_d = WRESP;
      end
      WRESP: begin
        b_valid = 1'b1;
        if (axi_req_i.b_ready) state_d = IDLE;
      end
      RDATA: begin
        r_valid = 1'b1;
        if (axi_req_i.r_ready && cnt_q == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      aw_ready = 1'b0;
      ar_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      r_valid  = 1'b0;
    end
  end

  // FSM state, captured id/target and beat counter.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tgt_q   <= TGT_BAD;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q  <= axi_req_i.aw.id;
        cnt_q <= axi_req_i.aw.len;
        tgt_q <= stdio_decode(axi_req_i.aw.addr[31:2], BASE_ADDR[31:4], axi_req_i.aw.len);
      end else if (ar_hs) begin
        id_q  <= axi_req_i.ar.id;
        cnt_q <= axi_req_i.ar.len;
      end else if (w_hs || r_hs) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Sticky stderr flag and last error word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_code_o  <= STDIO_ERR_RST;
    end else if (w_hs && tgt_q == TGT_ERR && axi_req_i.w.strb != 4'd0) begin
      err_valid_o <= 1'b1;
      err_code_o  <= axi_req_i.w.data;
    end
  end

`ifdef MAGIA_STDIO_EOC_EN
  // Sticky end-of-computation flag and exit code; later writes overwrite.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eoc_valid_o <= 1'b0;
      exit_code_o <= '0;
    end else if (w_hs && tgt_q == TGT_EOC) begin
      eoc_valid_o <= 1'b1;
      exit_code_o <= axi_req_i.w.data;
    end
  end
`endif

  magia_stdio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs && push_req),
    .data_i  (axi_req_i.w.data[7:0]),
    .pop_i   (char_ready_i),
    .data_o  (char_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign char_valid_o = !fifo_empty;

  // Response channel assembly; payloads come straight from held registers.
  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready;
    axi_rsp_o.ar_ready = ar_ready;
    axi_rsp_o.w_ready  = w_ready;
    axi_rsp_o.b_valid  = b_valid;
    axi_rsp_o.b.id     = id_q;
    axi_rsp_o.b.resp   = (tgt_q == TGT_BAD) ? magia_pkg::AXI_RESP_SLVERR : magia_pkg::AXI_RESP_OKAY;
    axi_rsp_o.r_valid  = r_valid;
    axi_rsp_o.r.id     = id_q;
    axi_rsp_o.r.data   = '0;
    axi_rsp_o.r.resp   = magia_pkg::AXI_RESP_SLVERR;
    axi_rsp_o.r.last   = (cnt_q == 8'd0);
  end

endmodule

// File: tb/tb_magia_axi_stdio.sv
// Self-checking bench for magia_axi_stdio (table vectors + char scoreboard).
module tb_magia_axi_stdio;
  import magia_pkg::*;

  localparam int TMO = 50;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef MAGIA_STDIO_EOC_EN
  localparam logic [1:0] EOC_RESP = OKAY;
`else
  localparam logic [1:0] EOC_RESP = SLVERR;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  axi_default_req_t req;
  axi_default_rsp_t rsp;
  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        err_valid;
  logic [31:0] err_code;
`ifdef MAGIA_STDIO_EOC_EN
  logic        eoc_valid;
  logic [31:0] exit_code;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_chars[$];

  always #5 clk_i = ~clk_i;

  magia_axi_stdio dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .axi_req_i    (req),
    .axi_rsp_o    (rsp),
    .char_valid_o (char_valid),
    .char_data_o  (char_data),
    .char_ready_i (char_ready),
    .err_valid_o  (err_valid),
    .err_code_o   (err_code)
`ifdef MAGIA_STDIO_EOC_EN
    ,
    .eoc_valid_o  (eoc_valid),
    .exit_code_o  (exit_code)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every popped character must match the oldest expected one.
  always @(negedge clk_i) begin
    if (!rst_i && char_valid && char_ready) begin
      logic [31:0] exp;
      exp = (exp_chars.size() > 0) ? {24'd0, exp_chars.pop_front()} : 32'hDEAD_BEEF;
      check("char_data", {24'd0, char_data}, exp);
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id,
                           output logic [1:0] resp, output logic [3:0] bid, output int b_wait,
                           output logic [31:0] err_snap, output logic errv_snap);
    int t;
    req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
    req.aw.size = 3'd2; req.aw.burst = 2'b01; req.aw_valid = 1'b1;
    #1; t = 0;
    while (!rsp.aw_ready && t < TMO) begin @(posedge clk_i); #1; t++; end
    check("aw_handshake", 32'(t < TMO), 1);
    @(posedge clk_i); #1;
    req.aw_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      req.w.data = data; req.w.strb = strb; req.w.last = (b == int'(len)); req.w_valid = 1'b1;
      #1; t = 0;
      while (!rsp.w_ready && t < TMO) begin @(posedge clk_i); #1; t++; end
      check("w_handshake", 32'(t < TMO), 1);
      @(posedge clk_i); #1;
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    err_snap = err_code; errv_snap = err_valid;
    req.b_ready = 1'b1;
    b_wait = 0;
    while (!rsp.b_valid && b_wait < TMO) begin @(posedge clk_i); #1; b_wait++; end
    resp = rsp.b.resp; bid = rsp.b.id;
    @(posedge clk_i); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [7:0] len);
    int t, beats;
    logic done;
    req.ar.id = id; req.ar.addr = 32'hFFFF_0004; req.ar.len = len;
    req.ar.size = 3'd2; req.ar.burst = 2'b01; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    #1; t = 0;
    while (!rsp.ar_ready && t < TMO) begin @(posedge clk_i); #1; t++; end
    check("ar_handshake", 32'(t < TMO), 1);
    @(posedge clk_i); #1;
    req.ar_valid = 1'b0;
    beats = 0; done = 1'b0;
    while (!done && beats < int'(len) + 4) begin
      t = 0;
      while (!rsp.r_valid && t < TMO) begin @(posedge clk_i); #1; t++; end
      if (t >= TMO) begin
        check("r_valid_timeout", 32'(t < TMO), 1);
        done = 1'b1;
      end else begin
        check("r_resp", 32'(rsp.r.resp), 32'(SLVERR));
        check("r_data", rsp.r.data, 0);
        check("r_id", 32'(rsp.r.id), 32'(id));
        check("r_last", 32'(rsp.r.last), 32'(beats == int'(len)));
        done = rsp.r.last;
        @(posedge clk_i); #1;
        beats++;
      end
    end
    check("r_beats", beats, int'(len) + 1);
    req.r_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        push;
    logic [1:0]  resp;
    logic [31:0] err_code;
    logic        err_valid;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]  resp;
    logic [3:0]  bid;
    int          b_wait, t, highs;
    logic [31:0] esnap;
    logic        evsnap;

    req = '0;
    char_ready = 1'b1;

    vecs[0] = '{32'hFFFF_0004, 8'd0, 32'h0000_0048, 4'h1, 1'b1, OKAY,   32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{32'hFFFF_0004, 8'd0, 32'h0000_0069, 4'h1, 1'b1, OKAY,   32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{32'hFFFF_0004, 8'd0, 32'h0000_0058, 4'h2, 1'b0, OKAY,   32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{32'hFFFF_000C, 8'd0, 32'h0000_0011, 4'hF, 1'b0, SLVERR, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'hFFFE_0004, 8'd0, 32'h0000_0041, 4'h1, 1'b0, SLVERR, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{32'hFFFF_0004, 8'd1, 32'h0000_0042, 4'h1, 1'b0, SLVERR, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{32'hFFFF_0000, 8'd0, 32'h0000_0003, 4'hF, 1'b0, OKAY,   32'h0000_0003, 1'b1};
    vecs[7] = '{32'hFFFF_0000, 8'd0, 32'h0000_0007, 4'h0, 1'b0, OKAY,   32'h0000_0003, 1'b1};
    vecs[8] = '{32'hFFFF_0008, 8'd0, 32'h0000_0055, 4'hF, 1'b0, EOC_RESP, 32'h0000_0003, 1'b1};
    vecs[9] = '{32'hFFFF_0008, 8'd0, 32'h0000_0000, 4'hF, 1'b0, EOC_RESP, 32'h0000_0003, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_aw_ready_low", 32'(rsp.aw_ready), 0);
    check("rst_ar_ready_low", 32'(rsp.ar_ready), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    check("idle_aw_ready", 32'(rsp.aw_ready), 1);
    check("idle_ar_ready", 32'(rsp.ar_ready), 1);
    check("rst_char_valid", 32'(char_valid), 0);
    check("rst_char_data", 32'(char_data), 0);
    check("rst_err_valid", 32'(err_valid), 0);
    check("rst_err_code", err_code, 32'hFFFF_FFFF);
    check("rst_b_valid", 32'(rsp.b_valid), 0);
`ifdef MAGIA_STDIO_EOC_EN
    check("rst_eoc_valid", 32'(eoc_valid), 0);
    check("rst_exit_code", exit_code, 0);
`endif

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].push) exp_chars.push_back(vecs[i].data[7:0]);
      axi_write(vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].strb, 4'(i),
                resp, bid, b_wait, esnap, evsnap);
      check($sformatf("v%0d_b_resp", i), 32'(resp), 32'(vecs[i].resp));
      check($sformatf("v%0d_b_id", i), 32'(bid), i);
      check($sformatf("v%0d_b_latency", i), b_wait, 0);
      check($sformatf("v%0d_err_code", i), esnap, vecs[i].err_code);
      check($sformatf("v%0d_err_valid", i), 32'(evsnap), 32'(vecs[i].err_valid));
    end
`ifdef MAGIA_STDIO_EOC_EN
    check("eoc_valid", 32'(eoc_valid), 1);
    check("exit_code", exit_code, 0);
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check("table_chars_drained", exp_chars.size(), 0);

    // Backpressure: fill the FIFO, the 9th stdout beat must wait for a pop.
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_chars.push_back(8'h61 + 8'(i));
      axi_write(32'hFFFF_0004, 8'd0, 32'h61 + 32'(i), 4'h1, 4'h2, resp, bid, b_wait, esnap, evsnap);
      check($sformatf("fill%0d_b_resp", i), 32'(resp), 32'(OKAY));
    end
    req.aw.id = 4'h9; req.aw.addr = 32'hFFFF_0004; req.aw.len = 8'd0; req.aw_valid = 1'b1;
    #1; t = 0;
    while (!rsp.aw_ready && t < TMO) begin @(posedge clk_i); #1; t++; end
    check("bp_aw_handshake", 32'(t < TMO), 1);
    @(posedge clk_i); #1;
    req.aw_valid = 1'b0;
    exp_chars.push_back(8'h7A);
    req.w.data = 32'h7A; req.w.strb = 4'h1; req.w.last = 1'b1; req.w_valid = 1'b1;
    #1; highs = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp.w_ready) highs++;
      @(posedge clk_i); #1;
    end
    check("bp_w_ready_held_low", highs, 0);
    char_ready = 1'b1;
    @(posedge clk_i); #1;
    char_ready = 1'b0;
    t = 0;
    while (!rsp.w_ready && t < 3) begin @(posedge clk_i); #1; t++; end
    check("bp_w_ready_after_pop", 32'(rsp.w_ready), 1);
    @(posedge clk_i); #1;
    req.w_valid = 1'b0; req.w.last = 1'b0;
    req.b_ready = 1'b1;
    t = 0;
    while (!rsp.b_valid && t < TMO) begin @(posedge clk_i); #1; t++; end
    check("bp_b_valid", 32'(rsp.b_valid), 1);
    check("bp_b_resp", 32'(rsp.b.resp), 32'(OKAY));
    check("bp_b_id", 32'(rsp.b.id), 32'h9);
    @(posedge clk_i); #1;
    req.b_ready = 1'b0;
    char_ready = 1'b1;
    t = 0;
    while (exp_chars.size() > 0 && t < TMO) begin @(posedge clk_i); #1; t++; end
    check("bp_chars_drained", exp_chars.size(), 0);

    // Same-cycle AW and AR: write (len 1 burst, SLVERR, no char) first, then read.
    req.ar.id = 4'h5; req.ar.len = 8'd0; req.ar_valid = 1'b1;
    req.aw.addr = 32'hFFFF_0004; req.aw.len = 8'd1; req.aw_valid = 1'b1;
    #1;
    check("arb_ar_ready_low", 32'(rsp.ar_ready), 0);
    check("arb_aw_ready_high", 32'(rsp.aw_ready), 1);
    axi_write(32'hFFFF_0004, 8'd1, 32'h51, 4'h1, 4'h6, resp, bid, b_wait, esnap, evsnap);
    check("arb_b_resp", 32'(resp), 32'(SLVERR));
    check("arb_b_id", 32'(bid), 32'h6);
    check("arb_no_char", 32'(char_valid), 0);
    axi_read(4'h5, 8'd0);

    // Multi-beat read.
    axi_read(4'h7, 8'd3);
    check("post_read_idle", 32'(rsp.aw_ready), 1);

    // Reset in WDATA aborts the transaction and flushes state.
    char_ready = 1'b0;
    axi_write(32'hFFFF_0004, 8'd0, 32'h52, 4'h1, 4'h1, resp, bid, b_wait, esnap, evsnap);
    check("pre_rst_char_valid", 32'(char_valid), 1);
    req.aw.id = 4'h3; req.aw.addr = 32'hFFFF_0000; req.aw.len = 8'd0; req.aw_valid = 1'b1;
    #1; t = 0;
    while (!rsp.aw_ready && t < TMO) begin @(posedge clk_i); #1; t++; end
    @(posedge clk_i); #1;
    req.aw_valid = 1'b0;
    #1;
    check("wdata_w_ready", 32'(rsp.w_ready), 1);
    check("wdata_aw_ready_low", 32'(rsp.aw_ready), 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("mid_rst_w_ready_low", 32'(rsp.w_ready), 0);
    rst_i = 1'b0;
    #1;
    check("abort_idle", 32'(rsp.aw_ready), 1);
    check("abort_no_b", 32'(rsp.b_valid), 0);
    check("abort_err_code", err_code, 32'hFFFF_FFFF);
    check("abort_err_valid", 32'(err_valid), 0);
    check("abort_fifo_empty", 32'(char_valid), 0);
    check("abort_char_data", 32'(char_data), 0);
`ifdef MAGIA_STDIO_EOC_EN
    check("abort_eoc_valid", 32'(eoc_valid), 0);
`endif
    char_ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("final_chars_drained", exp_chars.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
